// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Optional MD_DIVZERO_GUARD_EN: a divide by zero leaves HI/LO unchanged.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    // Result datapath works only on the captured operands.
    always_comb begin
        prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prod_u = 64'({32'd0, a_q} * {32'd0, b_q});
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b1;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    // Signed overflow: quotient wraps to the dividend.
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = 32'($signed(a_q) % $signed(b_q));
                    res_lo = 32'($signed(a_q) / $signed(b_q));
                end
            end
            OP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = a_q % b_q;
                    res_lo = a_q / b_q;
                end
            end
            default: res_we = 1'b0;
        endcase
`ifdef MD_DIVZERO_GUARD_EN
        if ((op_q == OP_DIV || op_q == OP_DIVU) && b_q == 32'd0) begin
            res_we = 1'b0;
        end
`endif
    end

    // Next-state: accept only when idle; count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (md_en) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference.
module tb_mult_div_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md_en(md_en),
        .md_op(md_op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Reference: architectural HI/LO after an operation, from plain integer arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (op)
            3'd1: begin
                sq = sx * sy;
                exp_hi = sq[63:32];
                exp_lo = sq[31:0];
            end
            3'd2: begin
                up = ux * uy;
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd3, 3'd4: begin
                if (y == 32'd0) begin
`ifndef MD_DIVZERO_GUARD_EN
                    exp_hi = x;
                    exp_lo = 32'hFFFF_FFFF;
`endif
                end else if (op == 3'd3) begin
                    sq = sx / sy;
                    sr = sx - sq * sy;
                    exp_hi = sr[31:0];
                    exp_lo = sq[31:0];
                end else begin
                    up = ux / uy;
                    exp_lo = up[31:0];
                    up = ux - up * uy;
                    exp_hi = up[31:0];
                end
            end
            3'd5: exp_hi = x;
            3'd6: exp_lo = x;
            default: ;
        endcase
    endfunction

    // Multi-cycle op; busy-cycle inputs are junk, with an optional mthi in cycle mthi_at.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int mthi_at);
        int n;
        n = (op == 3'd1 || op == 3'd2) ? int'(MULT_N) : int'(DIV_N);
        @(negedge clk);
        md_en = 1'b1; md_op = op; a = x; b = y;
        @(posedge clk); #1;
        check("busy_start", 32'(busy), 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == mthi_at) begin
                md_en = 1'b1; md_op = 3'd5; a = 32'h1234_5678; b = 32'd0;
            end else begin
                md_en = 1'($urandom_range(0, 1));
                md_op = 3'($urandom_range(0, 7));
                a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            if (k < n) begin
                if (busy !== 1'b1) check("busy_hold", 32'(busy), 32'd1);
                if (hi !== exp_hi) check("hi_hold", hi, exp_hi);
            end
        end
        md_en = 1'b0;
        ref_op(op, x, y);
        check("busy_end", 32'(busy), 32'd0);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
        @(negedge clk);
        md_en = 1'b1; md_op = op; a = x; b = $urandom;
        @(posedge clk); #1;
        md_en = 1'b0;
        ref_op(op, x, 32'd0);
        check("mt_busy", 32'(busy), 32'd0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; md_en = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu_hi_lit", hi, 32'd1);
        check("multu_lo_lit", lo, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_lo_lit", lo, 32'hFFFF_FFFD);
        check("div_hi_lit", hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd2, 0);
        check("divu_lo_lit", lo, 32'd3);
        check("divu_hi_lit", hi, 32'd1);

        run_op(3'd1, 32'd1000, 32'hFFFF_FFF0, 3);
        check("ignore_mthi", hi, 32'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        run_mt(3'd5, 32'hAAAA_5555);
        run_mt(3'd6, 32'h0F0F_F0F0);
        run_op(3'd3, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0);

        // Reset in the 4th busy cycle of a div aborts it for good.
        @(negedge clk);
        md_en = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        md_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_hi", hi, 32'd0);
            check("post_rst_lo", lo, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (rop >= 3'd5) run_mt(rop, ra);
            else run_op(rop, ra, rb, 0);
        end

        // Reserved and none opcodes change nothing.
        @(negedge clk);
        md_en = 1'b1; md_op = 3'd7; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        check("rsv_busy", 32'(busy), 32'd0);
        check("rsv_hi", hi, exp_hi);
        @(negedge clk);
        md_op = 3'd0;
        @(posedge clk); #1;
        md_en = 1'b0;
        check("none_busy", 32'(busy), 32'd0);
        check("none_lo", lo, exp_lo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
